read_feeder: RTL and testbench

Upstream stage of `ReadMemReseed3`. It accepts reads as a byte stream over AXI4-Stream and decodes ASCII bases into the package `Symbol` type. Reads are held in a two-entry ping-pong buffer. Each buffered read, with its `read_id`, is dispatched to the MEM engine through the `start`/`finish` handshake, so the host can stream the next read while the current one is being seeded.

---
 rtl/read_feeder_pkg.sv | 38 +++
 rtl/read_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_read_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_feeder_pkg.sv
// read_feeder_pkg
//   Shared types and helpers for the read feeder and its testbench.
//   - Symbol      : 3-bit decoded base (A, C, G, T, N)
//   - AsciiToSym  : ASCII byte to Symbol, case-insensitive; anything
//                   that is not A/C/G/T decodes to sym_N
//   - disp_state_e: dispatch FSM state encoding
package read_feeder_pkg;

  localparam int FrameHdrBytes = 4;
  localparam int SymW          = 3;

  typedef enum logic [SymW-1:0] {
    sym_A = 3'd0,
    sym_C = 3'd1,
    sym_G = 3'd2,
    sym_T = 3'd3,
    sym_N = 3'd4
  } Symbol;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } disp_state_e;

  function automatic Symbol AsciiToSym(input logic [7:0] c);
    Symbol s;
    case (c)
      8'h41, 8'h61: s = sym_A;
      8'h43, 8'h63: s = sym_C;
      8'h47, 8'h67: s = sym_G;
      8'h54, 8'h74: s = sym_T;
      default:      s = sym_N;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/read_feeder.sv
// read_feeder
//   Accepts reads as a byte stream (4 little-endian id bytes followed by
//   READ_LEN ASCII bases), decodes the bases into Symbols, holds up to
//   two complete reads in a ping-pong buffer and dispatches them one at a
//   time to the MEM engine with a start/finish handshake.
//
// Ports
//   clk_i, reset_n_i      : clock, synchronous active-low reset
//   s_axis_tdata_i/tvalid_i/tlast_i, s_axis_tready_o : byte stream in
//   read_o                : decoded read, base i at [i*SymW +: SymW]
//   read_id_o             : id of the read on read_o
//   start_o               : one-cycle dispatch pulse
//   finish_i              : one-cycle completion pulse from the engine
//   busy_i                : engine busy, holds off dispatch
//   err_short_o           : pulse, frame ended early and was dropped
//   err_long_o            : pulse, frame overran and was dropped
//   reads_done_o          : count of accepted finish pulses (wraps)
//
// Dispatch FSM
//   state    | meaning
//   ST_IDLE  | waiting for buf[rp] full and engine not busy
//   ST_START | start_o high for this single cycle
//   ST_RUN   | engine seeding buf[rp]; finish_i releases the buffer
module read_feeder
  import read_feeder_pkg::*;
#(
  parameter int READ_LEN = 76,
  parameter int ID_W     = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [7:0]               s_axis_tdata_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  input  logic                     s_axis_tlast_i,
  output logic [READ_LEN*SymW-1:0] read_o,
  output logic [ID_W-1:0]          read_id_o,
  output logic                     start_o,
  input  logic                     finish_i,
  input  logic                     busy_i,
  output logic                     err_short_o,
  output logic                     err_long_o,
  output logic [31:0]              reads_done_o
);

  localparam int Frm = FrameHdrBytes + READ_LEN;
  localparam int BcW = $clog2(Frm);
  localparam logic [BcW-1:0] BcLast = BcW'(Frm - 1);
  localparam logic [BcW-1:0] BcHdr  = BcW'(FrameHdrBytes);
  localparam logic [SymW-1:0] SymNBits = sym_N;

  logic [1:0]     full_q, full_d;
  logic           wp_q, wp_d;
  logic           rp_q, rp_d;
  logic [BcW-1:0] bc_q, bc_d;
  logic           drop_q, drop_d;
  logic           err_short_q, err_short_d;
  logic           err_long_q, err_long_d;
  logic [31:0]    done_q, done_d;
  disp_state_e    state_q, state_d;

  logic [31:0]              hdr_q   [2];
  logic [READ_LEN*SymW-1:0] bases_q [2];

  logic           hs;
  logic           frame_ok;
  logic           release_rd;
  logic [BcW-1:0] base_off;

  // While dropping an overlong frame, bytes are swallowed regardless of
  // buffer state so the stream can resynchronise on the next tlast.
  assign s_axis_tready_o = reset_n_i && (drop_q || !full_q[wp_q]);
  assign hs              = s_axis_tvalid_i && s_axis_tready_o;
  assign base_off        = bc_q - BcHdr;

  // ---------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------
  always_comb begin
    bc_d        = bc_q;
    drop_d      = drop_q;
    wp_d        = wp_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    frame_ok    = 1'b0;
    if (hs) begin
      if (drop_q) begin
        if (s_axis_tlast_i) begin
          drop_d     = 1'b0;
          err_long_d = 1'b1;
        end
      end else if (s_axis_tlast_i) begin
        bc_d = '0;
        if (bc_q == BcLast) begin
          frame_ok = 1'b1;
          wp_d     = ~wp_q;
        end else begin
          err_short_d = 1'b1;
        end
      end else if (bc_q == BcLast) begin
        bc_d   = '0;
        drop_d = 1'b1;
      end else begin
        bc_d = bc_q + BcW'(1);
      end
    end
  end

  // Completion sets full[wp] while finish clears full[rp]; both can
  // happen in one cycle because wp != rp whenever both are active.
  always_comb begin
    full_d = full_q;
    rp_d   = rp_q;
    done_d = done_q;
    if (release_rd) begin
      full_d[rp_q] = 1'b0;
      rp_d         = ~rp_q;
      done_d       = done_q + 32'd1;
    end
    if (frame_ok) begin
      full_d[wp_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      full_q      <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      bc_q        <= '0;
      drop_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      done_q      <= '0;
    end else begin
      full_q      <= full_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      bc_q        <= bc_d;
      drop_q      <= drop_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      done_q      <= done_d;
    end
  end

  // Payload storage needs no reset: outputs are masked until the
  // buffer is marked full, and a full buffer is never written.
  // The header byte lane uses bc[1:0] since the header is 4 bytes.
  always_ff @(posedge clk_i) begin
    if (hs && !drop_q) begin
      if (bc_q < BcHdr) begin
        hdr_q[wp_q][{bc_q[1:0], 3'b000} +: 8] <= s_axis_tdata_i;
      end else begin
        bases_q[wp_q][base_off*SymW +: SymW] <= AsciiToSym(s_axis_tdata_i);
      end
    end
  end

  // ---------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (full_q[rp_q] && !busy_i) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (finish_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_o    = (state_q == ST_START);
    release_rd = (state_q == ST_RUN) && finish_i;
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  always_comb begin
    read_id_o = '0;
    read_o    = {READ_LEN{SymNBits}};
    if (full_q[rp_q]) begin
      read_id_o = ID_W'(hdr_q[rp_q]);
      read_o    = bases_q[rp_q];
    end
  end

  assign err_short_o  = err_short_q;
  assign err_long_o   = err_long_q;
  assign reads_done_o = done_q;

endmodule

// File: tb/tb_read_feeder.sv
`timescale 1ns/1ps
module tb_read_feeder;
  import read_feeder_pkg::*;

  localparam int READ_LEN = 76;
  localparam int ID_W     = 32;
  localparam int FRM      = 4 + READ_LEN;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [7:0]               tdata;
  logic                     tvalid, tready, tlast;
  logic [READ_LEN*SymW-1:0] read_v;
  logic [ID_W-1:0]          read_id;
  logic                     start, finish, busy;
  logic                     err_s, err_l;
  logic [31:0]              done;

  always #5 clk = ~clk;

  read_feeder #(.READ_LEN(READ_LEN), .ID_W(ID_W)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .s_axis_tdata_i (tdata),
    .s_axis_tvalid_i(tvalid),
    .s_axis_tready_o(tready),
    .s_axis_tlast_i (tlast),
    .read_o         (read_v),
    .read_id_o      (read_id),
    .start_o        (start),
    .finish_i       (finish),
    .busy_i         (busy),
    .err_short_o    (err_s),
    .err_long_o     (err_l),
    .reads_done_o   (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]              id;
    logic [READ_LEN*SymW-1:0] bases;
  } rd_t;

  rd_t         mq[$];          // completed reads, oldest first (at most 2)
  byte unsigned mfrm[$];       // bytes of the frame being received
  bit          m_drop = 0;
  int          m_phase = 0;    // 0 waiting, 1 start pulse, 2 engine running
  logic [31:0] m_done = 0;
  bit          m_errs = 0, m_errl = 0;
  bit          model_live = 0;

  function automatic logic [SymW-1:0] ref_sym(input byte unsigned b);
    string up = "ACGT";
    Symbol tbl[4] = '{sym_A, sym_C, sym_G, sym_T};
    byte unsigned c = b;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    for (int k = 0; k < 4; k++) if (c == up[k]) return tbl[k];
    return sym_N;
  endfunction

  function automatic logic [READ_LEN*SymW-1:0] all_n();
    logic [READ_LEN*SymW-1:0] v;
    for (int k = 0; k < READ_LEN; k++) v[k*SymW +: SymW] = sym_N;
    return v;
  endfunction

  function automatic bit m_tready();
    return reset_n && (m_drop || mq.size() < 2);
  endfunction

  always @(posedge clk) begin
    bit hs, fin;
    rd_t r;
    model_live = 1;
    if (!reset_n) begin
      mq.delete(); mfrm.delete();
      m_drop = 0; m_phase = 0; m_done = 0; m_errs = 0; m_errl = 0;
    end else begin
      hs  = tvalid && m_tready();
      fin = (m_phase == 2) && finish;
      m_errs = 0; m_errl = 0;
      case (m_phase)
        0: if (mq.size() > 0 && !busy) m_phase = 1;
        1: m_phase = 2;
        default: if (finish) m_phase = 0;
      endcase
      if (fin) begin
        void'(mq.pop_front());
        m_done = m_done + 1;
      end
      if (hs) begin
        if (m_drop) begin
          if (tlast) begin m_drop = 0; m_errl = 1; end
        end else begin
          mfrm.push_back(tdata);
          if (tlast) begin
            if (mfrm.size() == FRM) begin
              r.id = {mfrm[3], mfrm[2], mfrm[1], mfrm[0]};
              for (int k = 0; k < READ_LEN; k++) r.bases[k*SymW +: SymW] = ref_sym(mfrm[4+k]);
              mq.push_back(r);
            end else begin
              m_errs = 1;
            end
            mfrm.delete();
          end else if (mfrm.size() == FRM) begin
            m_drop = 1;
            mfrm.delete();
          end
        end
      end
    end
  end

  // ---------------- compare + monitors ----------------
  int n_start = 0, n_errs = 0, n_errl = 0;

  always @(negedge clk) begin
    logic [READ_LEN*SymW-1:0] ev;
    logic [31:0] eid;
    if (model_live) begin
      if (mq.size() > 0) begin ev = mq[0].bases; eid = mq[0].id; end
      else begin ev = all_n(); eid = '0; end
      chk("tready", 256'(tready), 256'(m_tready()));
      chk("start", 256'(start), 256'(m_phase == 1));
      chk("err_short", 256'(err_s), 256'(m_errs));
      chk("err_long", 256'(err_l), 256'(m_errl));
      chk("reads_done", 256'(done), 256'(m_done));
      chk("read_id", 256'(read_id), 256'(eid));
      chk("read", 256'(read_v), 256'(ev));
      if (start === 1'b1) n_start++;
      if (err_s === 1'b1) n_errs++;
      if (err_l === 1'b1) n_errl++;
    end
  end

  // ---------------- MEM engine stand-in ----------------
  bit hold = 0, stray_en = 0, busy_rand = 0, stray_once = 0;

  initial begin : engine
    bit pending;
    pending = 0;
    finish  = 0;
    busy    = 0;
    forever begin
      @(posedge clk); #1;
      finish = 0;
      busy   = busy_rand && ($urandom % 3 == 0);
      if (!reset_n) pending = 0;
      else if (start === 1'b1) pending = 1;
      else if (stray_once) begin finish = 1; stray_once = 0; end
      else if (pending && !hold && ($urandom % 3 == 0)) begin finish = 1; pending = 0; end
      else if (!pending && stray_en && ($urandom % 16 == 0)) finish = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  byte unsigned frm[$];
  string alpha = "ACGTacgtNx?";
  bit gaps = 0;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mk_frame(input logic [31:0] id);
    frm.delete();
    for (int k = 0; k < 4; k++) frm.push_back(id[8*k +: 8]);
    for (int k = 0; k < READ_LEN; k++) frm.push_back(alpha[$urandom_range(0, 10)]);
  endtask

  task automatic wait_hs();
    bit rdy;
    int n = 0;
    do begin
      @(negedge clk); rdy = tready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 3000);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL handshake_timeout got=0 want=1 t=%0t", $time);
    end
  endtask

  task automatic send(input int last_at);
    for (int k = 0; k < frm.size(); k++) begin
      if (gaps && ($urandom % 5 == 0)) begin tvalid = 0; cyc(1); end
      tvalid = 1; tdata = frm[k]; tlast = (k == last_at);
      wait_hs();
    end
    tvalid = 0; tlast = 0;
  endtask

  task automatic wait_start(output bit got);
    got = 0;
    for (int n = 0; n < 400 && !got; n++) begin @(negedge clk); got = (start === 1'b1); end
    checks++;
    if (!got) begin errors++; $display("FAIL start_timeout got=0 want=1 t=%0t", $time); end
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || m_phase != 0) && n < 3000) begin cyc(1); n++; end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL drain_timeout got=%0d want=0", mq.size()); end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    bit got;
    int s0, e0, r, len;
    logic [31:0] rid;
    reset_n = 0; tvalid = 0; tdata = 0; tlast = 0;
    cyc(2);
    @(negedge clk);
    chk("rst_tready", 256'(tready), 256'(0));
    chk("rst_start", 256'(start), 256'(0));
    chk("rst_read_id", 256'(read_id), 256'(0));
    chk("rst_read", 256'(read_v), 256'(all_n()));
    chk("rst_errs", 256'({err_s, err_l}), 256'(0));
    @(posedge clk); #1;
    reset_n = 1;
    cyc(2);

    // single read
    mk_frame(32'h01234567);
    frm[4] = "T"; frm[FRM-1] = "C";
    send(FRM-1);
    wait_start(got);
    if (got) begin
      chk("t1_id", 256'(read_id), 256'(32'h01234567));
      chk("t1_read0", 256'(read_v[2:0]), 256'(sym_T));
      chk("t1_read75", 256'(read_v[75*SymW +: SymW]), 256'(sym_C));
    end
    for (int n = 0; n < 100 && done == 0; n++) @(negedge clk);
    chk("t1_done", 256'(done), 256'(1));
    cyc(1);

    // lowercase / N decode
    mk_frame(32'h000000A5);
    frm[4] = "a"; frm[5] = "c"; frm[6] = "g"; frm[7] = "t"; frm[8] = "N"; frm[9] = "?";
    send(FRM-1);
    wait_start(got);
    if (got) begin
      chk("lc_a", 256'(read_v[0*SymW +: SymW]), 256'(sym_A));
      chk("lc_c", 256'(read_v[1*SymW +: SymW]), 256'(sym_C));
      chk("lc_g", 256'(read_v[2*SymW +: SymW]), 256'(sym_G));
      chk("lc_t", 256'(read_v[3*SymW +: SymW]), 256'(sym_T));
      chk("lc_N", 256'(read_v[4*SymW +: SymW]), 256'(sym_N));
      chk("lc_q", 256'(read_v[5*SymW +: SymW]), 256'(sym_N));
    end
    cyc(1);
    drain();

    // short frame: tlast on byte 50
    s0 = n_start; e0 = n_errs;
    mk_frame(32'h11110000);
    frm = frm[0:50];
    send(50);
    cyc(6);
    chk("short_err", 256'(n_errs - e0), 256'(1));
    chk("short_nostart", 256'(n_start - s0), 256'(0));
    mk_frame(32'h22220000);
    send(FRM-1);
    wait_start(got);
    if (got) chk("short_next_id", 256'(read_id), 256'(32'h22220000));
    cyc(1);
    drain();

    // long frame: 90 bytes, tlast on the last
    s0 = n_start; e0 = n_errl;
    mk_frame(32'h33330000);
    for (int k = 0; k < 10; k++) frm.push_back(8'h41);
    send(89);
    cyc(6);
    chk("long_err", 256'(n_errl - e0), 256'(1));
    chk("long_nostart", 256'(n_start - s0), 256'(0));

    // back-pressure: three frames with finish withheld
    hold = 1;
    s0 = n_start;
    mk_frame(32'hB0000001); send(FRM-1);
    mk_frame(32'hB0000002); send(FRM-1);
    cyc(3);
    @(negedge clk);
    chk("bp_tready", 256'(tready), 256'(0));
    chk("bp_starts", 256'(n_start - s0), 256'(1));
    @(posedge clk); #1;
    fork
      begin
        mk_frame(32'hB0000003);
        send(FRM-1);
      end
      begin
        cyc(10);
        @(negedge clk);
        chk("bp_tready_held", 256'(tready), 256'(0));
        @(posedge clk); #1;
        hold = 0;
        wait_start(got);
        if (got) chk("bp_id2", 256'(read_id), 256'(32'hB0000002));
      end
    join
    drain();

    // reset during RUN and during a partial frame
    hold = 1;
    mk_frame(32'hC0000001); send(FRM-1);
    wait_start(got);
    cyc(3);
    mk_frame(32'hC0000002);
    frm = frm[0:19];
    send(-1);
    reset_n = 0;
    cyc(2);
    @(negedge clk);
    chk("mr_tready", 256'(tready), 256'(0));
    chk("mr_start", 256'(start), 256'(0));
    chk("mr_done", 256'(done), 256'(0));
    chk("mr_read_id", 256'(read_id), 256'(0));
    @(posedge clk); #1;
    reset_n = 1;
    hold = 0;
    stray_once = 1;
    cyc(5);
    chk("mr_stray_done", 256'(done), 256'(0));
    mk_frame(32'hC0000003); send(FRM-1);
    wait_start(got);
    if (got) chk("mr_next_id", 256'(read_id), 256'(32'hC0000003));
    cyc(1);
    drain();

    // randomized traffic
    gaps = 1; busy_rand = 1; stray_en = 1;
    for (int i = 0; i < 30; i++) begin
      rid = $urandom;
      mk_frame(rid);
      r = $urandom % 10;
      if (r == 0) begin
        len = $urandom_range(1, FRM-1);
        frm = frm[0:len-1];
      end else if (r == 1) begin
        len = $urandom_range(1, 15);
        for (int k = 0; k < len; k++) frm.push_back(alpha[$urandom_range(0, 10)]);
      end
      send(frm.size() - 1);
      cyc($urandom_range(0, 3));
    end
    busy_rand = 0; stray_en = 0;
    drain();
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
